// File: rtl/gw_dff_delay_line.sv
// gw_dff_delay_line: WIDTH x DEPTH flip-flop delay line with a shared clock
// enable, a synchronous reset whose value is set by RESET_MODE, a clamped
// dynamic tap select, an optional output register and a saturating fill counter.
module gw_dff_delay_line #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 16,
  parameter string            RESET_MODE = "RESET",
  parameter logic [WIDTH-1:0] INIT       = {WIDTH{1'b0}},
  parameter bit               OREG       = 1'b0,
  parameter int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int               CW         = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    ADDR,
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    FILL_CNT,
  output logic             FULL
);

  // Value loaded into every stage (and the output register) on RESET.
  localparam logic [WIDTH-1:0] RV =
    (RESET_MODE == "SET")  ? {WIDTH{1'b1}} :
    (RESET_MODE == "INIT") ? INIT          :
                             {WIDTH{1'b0}};

  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  // A misspelt mode would otherwise silently fall back to all-zero reset.
  if (RESET_MODE != "RESET" && RESET_MODE != "SET" && RESET_MODE != "INIT") begin : g_bad_mode
    $error("gw_dff_delay_line: unknown RESET_MODE \"%s\"", RESET_MODE);
  end

  // Declaration initialisers give the FPGA power-up contents.
  logic [WIDTH-1:0] stage_reg [DEPTH] = '{default: INIT};
  logic [CW-1:0]    fill_reg          = '0;
  logic [WIDTH-1:0] tap;

  // Shift chain: reset has priority, otherwise shift by one stage on CE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RV;
      end
    end else if (CE) begin
      stage_reg[0] <= D;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  // Fill counter: number of CE shifts since reset, saturating at DEPTH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fill_reg <= '0;
    end else if (CE && (fill_reg != FILL_MAX)) begin
      fill_reg <= fill_reg + 1'b1;
    end
  end

  // Tap mux: any ADDR beyond the last stage falls through to stage DEPTH-1.
  always_comb begin
    tap = stage_reg[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (ADDR == AW'(k)) begin
        tap = stage_reg[k];
      end
    end
  end

  if (OREG) begin : g_oreg
    logic [WIDTH-1:0] q_reg = INIT;

    // Output register samples the pre-shift tap, adding one CE cycle of latency.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        q_reg <= RV;
      end else if (CE) begin
        q_reg <= tap;
      end
    end

    assign Q = q_reg;
  end else begin : g_comb
    assign Q = tap;
  end

  assign FILL_CNT = fill_reg;
  assign FULL     = (fill_reg == FILL_MAX);

endmodule

// File: tb/tb_gw_dff_delay_line.sv
// Directed bench for gw_dff_delay_line: four instances cover the default
// combinational tap, the registered output, SET reset mode and INIT/DEPTH=1.
module tb_gw_dff_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: defaults, OREG=0, ADDR widened so out-of-range taps can be driven.
  logic       a_reset = 0, a_ce = 0, a_full;
  logic [7:0] a_d = 0, a_q;
  logic [4:0] a_addr = 0, a_fill;
  gw_dff_delay_line #(.WIDTH(8), .DEPTH(16), .RESET_MODE("RESET"), .INIT(8'h00),
                      .OREG(1'b0), .AW(5)) dut_a (
    .CLK(clk), .RESET(a_reset), .CE(a_ce), .D(a_d), .ADDR(a_addr),
    .Q(a_q), .FILL_CNT(a_fill), .FULL(a_full));

  // Instance B: registered output.
  logic       b_reset = 0, b_ce = 0, b_full;
  logic [7:0] b_d = 0, b_q;
  logic [3:0] b_addr = 0;
  logic [4:0] b_fill;
  gw_dff_delay_line #(.WIDTH(8), .DEPTH(16), .RESET_MODE("RESET"), .INIT(8'h00),
                      .OREG(1'b1)) dut_b (
    .CLK(clk), .RESET(b_reset), .CE(b_ce), .D(b_d), .ADDR(b_addr),
    .Q(b_q), .FILL_CNT(b_fill), .FULL(b_full));

  // Instance C: SET reset mode.
  logic       c_reset = 0, c_ce = 0, c_full;
  logic [7:0] c_d = 0, c_q;
  logic [3:0] c_addr = 0;
  logic [4:0] c_fill;
  gw_dff_delay_line #(.WIDTH(8), .DEPTH(16), .RESET_MODE("SET"), .INIT(8'h00),
                      .OREG(1'b0)) dut_c (
    .CLK(clk), .RESET(c_reset), .CE(c_ce), .D(c_d), .ADDR(c_addr),
    .Q(c_q), .FILL_CNT(c_fill), .FULL(c_full));

  // Instance D: INIT mode, single stage.
  logic       d_reset = 0, d_ce = 0, d_full;
  logic [7:0] d_d = 0, d_q;
  logic [0:0] d_addr = 0, d_fill;
  gw_dff_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_MODE("INIT"), .INIT(8'h5A),
                      .OREG(1'b0)) dut_d (
    .CLK(clk), .RESET(d_reset), .CE(d_ce), .D(d_d), .ADDR(d_addr),
    .Q(d_q), .FILL_CNT(d_fill), .FULL(d_full));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    // Power-up contents before any reset
    chk("pwr_a_q",    32'(a_q),    32'h00);
    chk("pwr_c_q",    32'(c_q),    32'h00);
    chk("pwr_d_q",    32'(d_q),    32'h5A);
    chk("pwr_a_fill", 32'(a_fill), 0);
    chk("pwr_a_full", 32'(a_full), 0);

    // 1: CE=0 for five clocks, nothing moves
    a_d = 8'hEE;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_q",    32'(a_q),    32'h00);
    chk("t1_fill", 32'(a_fill), 0);
    chk("t1_full", 32'(a_full), 0);
    $display("t1 idle q=%h fill=%0d", a_q, a_fill);

    // 2: reset then shift 1..20 with ADDR=3
    a_reset = 1; tick(); a_reset = 0;
    chk("t2_rst_q",    32'(a_q),    32'h00);
    chk("t2_rst_fill", 32'(a_fill), 0);
    a_addr = 5'd3; a_ce = 1;
    for (int i = 1; i <= 20; i++) begin
      a_d = 8'(i);
      tick();
      $display("t2 edge=%0d d=%h q=%h fill=%0d full=%b", i, a_d, a_q, a_fill, a_full);
      chk("t2_q",    32'(a_q),    (i >= 4) ? 32'(i - 3) : 32'h00);
      chk("t2_fill", 32'(a_fill), (i >= 16) ? 16 : 32'(i));
      chk("t2_full", 32'(a_full), (i >= 16) ? 1 : 0);
    end
    // CE low: hold everything
    a_ce = 0; a_d = 8'h99;
    tick(); tick();
    chk("t2_hold_q",    32'(a_q),    17);
    chk("t2_hold_fill", 32'(a_fill), 16);

    // 5: chain 0..15, then sweep ADDR combinationally
    a_ce = 1;
    for (int i = 0; i < 16; i++) begin
      a_d = 8'(i);
      tick();
    end
    a_ce = 0;
    for (int k = 0; k < 16; k++) begin
      a_addr = 5'(k);
      #1;
      $display("t5 addr=%0d q=%h", a_addr, a_q);
      chk("t5_sweep", 32'(a_q), 32'(15 - k));
    end
    a_addr = 5'd20; #1;
    chk("t5_clamp20", 32'(a_q), 32'h00);
    a_addr = 5'd0; #1;
    chk("t5_addr0", 32'(a_q), 32'h0F);
    // Reset mid-operation with CE high discards history
    a_ce = 1; a_reset = 1; a_d = 8'h44;
    tick();
    a_reset = 0; a_ce = 0;
    chk("t5_rst_q",    32'(a_q),    32'h00);
    chk("t5_rst_fill", 32'(a_fill), 0);
    chk("t5_rst_full", 32'(a_full), 0);

    // 3: registered output, latency ADDR+2 counted in CE edges
    b_reset = 1; tick(); b_reset = 0;
    chk("t3_rst_q", 32'(b_q), 32'h00);
    b_addr = 4'd0; b_ce = 1; b_d = 8'hA5;
    tick();
    chk("t3_e1_q", 32'(b_q), 32'h00);
    b_ce = 0; b_d = 8'h00;
    tick(); tick();
    chk("t3_gap_q", 32'(b_q), 32'h00);
    chk("t3_gap_fill", 32'(b_fill), 1);
    b_ce = 1;
    tick();
    $display("t3 second CE edge q=%h", b_q);
    chk("t3_e2_q", 32'(b_q), 32'hA5);
    tick();
    chk("t3_e3_q", 32'(b_q), 32'h00);
    b_addr = 4'd1;
    b_d = 8'h11; tick();
    b_d = 8'h22; tick();
    chk("t3_a1_pre", 32'(b_q), 32'h00);
    b_d = 8'h33; tick();
    chk("t3_a1_q", 32'(b_q), 32'h11);
    b_reset = 1; tick(); b_reset = 0; b_ce = 0;
    chk("t3_rst2_q",    32'(b_q),    32'h00);
    chk("t3_rst2_fill", 32'(b_fill), 0);

    // 4: SET mode, fill with 3C, reset with CE=1 and D=77
    c_reset = 1; tick(); c_reset = 0;
    chk("t4_rst_q", 32'(c_q), 32'hFF);
    c_ce = 1; c_d = 8'h3C;
    for (int i = 0; i < 16; i++) tick();
    c_ce = 0;
    chk("t4_fill", 32'(c_fill), 16);
    chk("t4_full", 32'(c_full), 1);
    c_addr = 4'd15; #1;
    chk("t4_last", 32'(c_q), 32'h3C);
    c_reset = 1; c_ce = 1; c_d = 8'h77;
    tick();
    c_reset = 0; c_ce = 0;
    chk("t4_fill0", 32'(c_fill), 0);
    chk("t4_full0", 32'(c_full), 0);
    for (int k = 0; k < 16; k++) begin
      c_addr = 4'(k);
      #1;
      chk("t4_stage", 32'(c_q), 32'hFF);
    end
    $display("t4 after SET reset q=%h fill=%0d", c_q, c_fill);

    // 6: INIT mode, DEPTH=1
    d_ce = 1; d_d = 8'h22; tick();
    chk("t6_load", 32'(d_q), 32'h22);
    d_ce = 0; d_reset = 1; tick(); d_reset = 0;
    chk("t6_rst_q",    32'(d_q),    32'h5A);
    chk("t6_rst_fill", 32'(d_fill), 0);
    d_d = 8'h11; tick();
    chk("t6_hold", 32'(d_q), 32'h5A);
    d_addr = 1'b1; d_ce = 1; tick(); d_ce = 0;
    $display("t6 CE edge q=%h fill=%0d full=%b", d_q, d_fill, d_full);
    chk("t6_cap",  32'(d_q),    32'h11);
    chk("t6_fill", 32'(d_fill), 1);
    chk("t6_full", 32'(d_full), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
